// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - AES-128 types, tables and round/key-schedule helper functions
// Provides: state_t, word_t, fsm_t; SBOX, INV_SBOX, RCON; xtime, gmul, sub_word, rot_word,
//           key_step, inv_key_step, inv_shift_rows, inv_sub_bytes, inv_mix_columns.
// Byte i of a 128-bit block sits at bits [127-8*i -: 8] (FIPS-197 column-major order).
package aes_pkg;

    typedef logic [127:0] state_t;
    typedef logic [31:0]  word_t;
    typedef enum logic [1:0] {IDLE, KEYEXP, INIT, ROUND} fsm_t;

    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    localparam logic [0:255][7:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
    };

    // Entries 1..10 are the AES-128 round constants; the zero padding lets the 4-bit
    // round counter index the table directly without a range guard.
    localparam logic [0:15][7:0] RCON = {
        8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
        8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
    };

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Multiplication in GF(2^8) mod 0x11b; with a constant b this folds to a few XORs.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    function automatic word_t sub_word(input word_t w);
        return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
    endfunction

    function automatic word_t rot_word(input word_t w);
        return {w[23:0], w[31:24]};
    endfunction

    function automatic state_t key_step(input state_t k, input logic [7:0] rc);
        word_t w0, w1, w2, w3;
        w0 = k[127:96] ^ sub_word(rot_word(k[31:0])) ^ {rc, 24'h0};
        w1 = k[95:64] ^ w0;
        w2 = k[63:32] ^ w1;
        w3 = k[31:0]  ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    // Undo key_step: recover words 3..1 first, since w0 depends on the earlier w3.
    function automatic state_t inv_key_step(input state_t k, input logic [7:0] rc);
        word_t w0, w1, w2, w3;
        w3 = k[31:0]  ^ k[63:32];
        w2 = k[63:32] ^ k[95:64];
        w1 = k[95:64] ^ k[127:96];
        w0 = k[127:96] ^ sub_word(rot_word(w3)) ^ {rc, 24'h0};
        return {w0, w1, w2, w3};
    endfunction

    // Row r of the output takes column (c - r) mod 4 of the input.
    function automatic state_t inv_shift_rows(input state_t s);
        state_t r;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            for (int row = 0; row < 4; row++) begin
                r[127 - 8*(row + 4*c) -: 8] = s[127 - 8*(row + 4*((c - row + 4) % 4)) -: 8];
            end
        end
        return r;
    endfunction

    function automatic state_t inv_sub_bytes(input state_t s);
        state_t r;
        r = '0;
        for (int i = 0; i < 16; i++) begin
            r[127 - 8*i -: 8] = INV_SBOX[s[127 - 8*i -: 8]];
        end
        return r;
    endfunction

    function automatic state_t inv_mix_columns(input state_t s);
        state_t r;
        logic [7:0] a0, a1, a2, a3;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127 - 32*c -: 8];
            a1 = s[119 - 32*c -: 8];
            a2 = s[111 - 32*c -: 8];
            a3 = s[103 - 32*c -: 8];
            r[127 - 32*c -: 8] = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
            r[119 - 32*c -: 8] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
            r[111 - 32*c -: 8] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
            r[103 - 32*c -: 8] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
        end
        return r;
    endfunction

endpackage

// File: rtl/aes_decrypt_if.sv
// rtl/aes_decrypt_if.sv - request/result bundle of the AES-128 decrypt core
// Signals: start, cipher_text, key (requester -> core); plain_text, ready, busy (core -> requester).
// Modports: master = requester side, slave = decrypt core side.
interface aes_decrypt_if;
    import aes_pkg::*;

    logic   start;
    state_t cipher_text;
    state_t key;
    state_t plain_text;
    logic   ready;
    logic   busy;

    modport master (
        output start, cipher_text, key,
        input  plain_text, ready, busy
    );

    modport slave (
        input  start, cipher_text, key,
        output plain_text, ready, busy
    );
endinterface

// File: rtl/aes_inv_round.sv
// rtl/aes_inv_round.sv - one combinational AES inverse round
// Inputs: state (current block), round_key, last (skip InvMixColumns for the final round).
// Output: next_state = InvMixColumns(InvSubBytes(InvShiftRows(state)) ^ round_key).
module aes_inv_round
    import aes_pkg::*;
(
    input  state_t state,
    input  state_t round_key,
    input  logic   last,
    output state_t next_state
);
    state_t keyed;

    assign keyed      = inv_sub_bytes(inv_shift_rows(state)) ^ round_key;
    assign next_state = last ? keyed : inv_mix_columns(keyed);
endmodule

// File: rtl/aes_decrypt.sv
// rtl/aes_decrypt.sv - iterative AES-128 inverse cipher with on-the-fly inverse key schedule
// Ports: clk, reset (synchronous, active-high), bus (aes_decrypt_if.slave):
//        start/cipher_text/key in; plain_text (registered), ready (1-cycle pulse), busy out.
// Sequence per operation: 10 KEYEXP cycles walk the key forward to k10, 1 INIT cycle applies
// k10 and steps back to k9, then 10 ROUND cycles each use rk and step it back one more key.
module aes_decrypt
    import aes_pkg::*;
#(
    parameter int NR = 10
) (
    input  logic         clk,
    input  logic         reset,
    aes_decrypt_if.slave bus
);
    fsm_t       state, state_next;
    state_t     ct_q, rk, st, plain_text_q, round_out;
    logic [3:0] rnd;
    logic       ready_q;
    logic       busy_c;
    logic       last_round;

    aes_inv_round u_round (
        .state      (st),
        .round_key  (rk),
        .last       (last_round),
        .next_state (round_out)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.start) state_next = KEYEXP;
            KEYEXP:  if (rnd == 4'(NR)) state_next = INIT;
            INIT:    state_next = ROUND;
            ROUND:   if (last_round) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy_c     = (state != IDLE);
        last_round = (state == ROUND) && (rnd == 4'd0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ct_q         <= '0;
            rk           <= '0;
            st           <= '0;
            rnd          <= 4'd0;
            plain_text_q <= '0;
            ready_q      <= 1'b0;
        end else begin
            ready_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        ct_q <= bus.cipher_text;
                        rk   <= bus.key;
                        rnd  <= 4'd1;
                    end
                end
                KEYEXP: begin
                    rk  <= key_step(rk, RCON[rnd]);
                    rnd <= rnd + 4'd1;
                end
                INIT: begin
                    st  <= ct_q ^ rk;
                    rk  <= inv_key_step(rk, RCON[NR]);
                    rnd <= 4'(NR - 1);
                end
                ROUND: begin
                    if (last_round) begin
                        plain_text_q <= round_out;
                        ready_q      <= 1'b1;
                    end else begin
                        st  <= round_out;
                        rk  <= inv_key_step(rk, RCON[rnd]);
                        rnd <= rnd - 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.plain_text = plain_text_q;
    assign bus.ready      = ready_q;
    assign bus.busy       = busy_c;
endmodule

// File: tb/tb_aes_decrypt.sv
// tb/tb_aes_decrypt.sv - self-checking bench for aes_decrypt against a byte-level AES model
module tb_aes_decrypt;
    localparam logic [127:0] K1   = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] P1   = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] KB   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] CB   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] PB   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] K10B = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    typedef logic [10:0][127:0] rk_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   rdy_q[$];

    logic [7:0] m_sbox  [256];
    logic [7:0] m_isbox [256];

    always #5 clk = ~clk;

    aes_decrypt_if bus ();

    aes_decrypt #(.NR(10)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40) $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // ---------------- reference model: textbook AES on byte arrays ----------------
    function automatic logic [7:0] m_mul(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] acc;
        acc = 16'h0;
        for (int i = 0; i < 8; i++) if (b[i]) acc = acc ^ (16'(a) << i);
        for (int i = 15; i >= 8; i--) if (acc[i]) acc = acc ^ (16'h011b << (i - 8));
        return acc[7:0];
    endfunction

    function automatic logic [7:0] m_rotl(input logic [7:0] b, input int n);
        logic [15:0] d;
        d = {b, b} << n;
        return d[15:8];
    endfunction

    // S-box from its definition: multiplicative inverse followed by the affine map.
    task automatic build_tables();
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv;
            logic [7:0] s;
            inv = 8'h00;
            for (int y = 1; y < 256; y++) if (m_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            s = inv ^ m_rotl(inv, 1) ^ m_rotl(inv, 2) ^ m_rotl(inv, 3) ^ m_rotl(inv, 4) ^ 8'h63;
            m_sbox[x]  = s;
            m_isbox[s] = 8'(x);
        end
    endtask

    function automatic rk_t m_expand(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        rk_t         rk;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t  = {t[23:0], t[31:24]};
                t  = {m_sbox[t[31:24]], m_sbox[t[23:16]], m_sbox[t[15:8]], m_sbox[t[7:0]]} ^ {rc, 24'h0};
                rc = m_mul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        return rk;
    endfunction

    function automatic logic [127:0] m_decrypt(input logic [127:0] ct, input logic [127:0] key);
        rk_t          rk;
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [7:0]   ic [4];
        logic [7:0]   acc;
        logic [127:0] blk;
        ic  = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
        rk  = m_expand(key);
        blk = ct ^ rk[10];
        for (int i = 0; i < 16; i++) s[i] = blk[127 - 8*i -: 8];
        for (int r = 9; r >= 0; r--) begin
            for (int c = 0; c < 4; c++)
                for (int row = 0; row < 4; row++)
                    t[row + 4*c] = m_isbox[s[row + 4*((c - row + 4) % 4)]];
            for (int i = 0; i < 16; i++) t[i] = t[i] ^ rk[r][127 - 8*i -: 8];
            if (r > 0) begin
                for (int c = 0; c < 4; c++)
                    for (int row = 0; row < 4; row++) begin
                        acc = 8'h00;
                        for (int k = 0; k < 4; k++) acc = acc ^ m_mul(ic[(k - row + 4) % 4], t[k + 4*c]);
                        s[row + 4*c] = acc;
                    end
            end else begin
                s = t;
            end
        end
        for (int i = 0; i < 16; i++) blk[127 - 8*i -: 8] = s[i];
        return blk;
    endfunction

    function automatic logic [127:0] m_encrypt(input logic [127:0] pt, input logic [127:0] key);
        rk_t          rk;
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [7:0]   mc [4];
        logic [7:0]   acc;
        logic [127:0] blk;
        mc  = '{8'h02, 8'h03, 8'h01, 8'h01};
        rk  = m_expand(key);
        blk = pt ^ rk[0];
        for (int i = 0; i < 16; i++) s[i] = blk[127 - 8*i -: 8];
        for (int r = 1; r <= 10; r++) begin
            for (int c = 0; c < 4; c++)
                for (int row = 0; row < 4; row++)
                    t[row + 4*c] = m_sbox[s[row + 4*((c + row) % 4)]];
            if (r < 10) begin
                for (int c = 0; c < 4; c++)
                    for (int row = 0; row < 4; row++) begin
                        acc = 8'h00;
                        for (int k = 0; k < 4; k++) acc = acc ^ m_mul(mc[(k - row + 4) % 4], t[k + 4*c]);
                        s[row + 4*c] = acc;
                    end
            end else begin
                s = t;
            end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ rk[r][127 - 8*i -: 8];
        end
        for (int i = 0; i < 16; i++) blk[127 - 8*i -: 8] = s[i];
        return blk;
    endfunction

    // ---------------- cycle model: one accepted request -> result 21 edges later ----------------
    logic [127:0] m_pt, m_exp;
    logic         m_ready;
    int           m_cnt  = 0;
    bit           m_live = 1'b0;

    always @(posedge clk) begin
        cyc++;
        m_ready = 1'b0;
        if (reset) begin
            m_pt   = '0;
            m_cnt  = 0;
            m_live = 1'b1;
        end else if (m_cnt == 0) begin
            if (bus.start) begin
                m_exp = m_decrypt(bus.cipher_text, bus.key);
                m_cnt = 21;
            end
        end else begin
            m_cnt--;
            if (m_cnt == 0) begin
                m_pt    = m_exp;
                m_ready = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (m_live) begin
            check("ready", 128'(bus.ready), 128'(m_ready));
            check("busy", 128'(bus.busy), 128'(m_cnt != 0));
            check("plain_text", bus.plain_text, m_pt);
            if (bus.ready === 1'b1) rdy_q.push_back(cyc);
        end
    end

    // ---------------- directed stimulus ----------------
    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic do_start(input logic [127:0] ct, input logic [127:0] k, output int t0);
        @(negedge clk);
        bus.cipher_text = ct;
        bus.key         = k;
        bus.start       = 1'b1;
        @(posedge clk);
        #1 t0 = cyc;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_ready(input int budget, output int rc);
        rc = -1;
        for (int i = 0; i < budget && rc < 0; i++) begin
            @(negedge clk);
            if (bus.ready === 1'b1) rc = cyc;
        end
        n_checks++;
        if (rc < 0) begin
            n_fail++;
            $display("FAIL ready_timeout: no ready within %0d cycles", budget);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, rc, r1, r2, n0;
        rk_t rkb;
        logic [127:0] pt, k;

        bus.start       = 1'b0;
        bus.cipher_text = '0;
        bus.key         = '0;
        build_tables();

        check("model_sbox_53", 128'(m_sbox[8'h53]), 128'h00ed);
        check("model_isbox_00", 128'(m_isbox[8'h00]), 128'h0052);
        rkb = m_expand(KB);
        check("model_k10_appb", rkb[10], K10B);
        check("model_enc_c1", m_encrypt(P1, K1), C1);
        check("model_dec_c1", m_decrypt(C1, K1), P1);
        check("model_dec_appb", m_decrypt(CB, KB), PB);

        repeat (3) @(negedge clk);
        check("reset_plain_text", bus.plain_text, '0);
        check("reset_ready", 128'(bus.ready), '0);
        check("reset_busy", 128'(bus.busy), '0);
        reset = 1'b0;

        // FIPS-197 C.1
        do_start(C1, K1, t0);
        wait_ready(40, rc);
        check_int("latency_c1", rc - t0, 21);
        check("pt_c1", bus.plain_text, P1);

        // FIPS-197 App. B, with the forward-expanded key visible on entry to INIT
        do_start(CB, KB, t0);
        repeat (10) @(negedge clk);
        check("rk_on_init", dut.rk, K10B);
        wait_ready(40, rc);
        check_int("latency_appb", rc - t0, 21);
        check("pt_appb", bus.plain_text, PB);

        // start held high: second request is sampled at the edge ending the idle ready cycle,
        // so the two ready pulses land 22 cycles apart
        @(negedge clk);
        bus.cipher_text = C1;
        bus.key         = K1;
        bus.start       = 1'b1;
        @(posedge clk);
        #1 t0 = cyc;
        @(negedge clk);
        bus.cipher_text = CB;
        bus.key         = KB;
        wait_ready(40, r1);
        check_int("b2b_latency", r1 - t0, 21);
        check("b2b_pt_c1", bus.plain_text, P1);
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        wait_ready(40, r2);
        check_int("b2b_spacing", r2 - r1, 22);
        check("b2b_pt_appb", bus.plain_text, PB);

        // starts while busy are dropped, inputs may change after capture
        repeat (3) @(negedge clk);
        n0 = rdy_q.size();
        do_start(C1, K1, t0);
        repeat (4) @(negedge clk);
        bus.start       = 1'b1;
        bus.cipher_text = CB;
        bus.key         = KB;
        @(negedge clk);
        bus.start       = 1'b0;
        bus.cipher_text = rand128();
        repeat (9) @(negedge clk);
        bus.start       = 1'b1;
        bus.cipher_text = rand128();
        bus.key         = rand128();
        @(negedge clk);
        bus.start = 1'b0;
        wait_ready(40, rc);
        check_int("ignore_latency", rc - t0, 21);
        check("ignore_pt_c1", bus.plain_text, P1);
        repeat (30) @(negedge clk);
        check_int("ignore_single_ready", rdy_q.size() - n0, 1);

        // reset in the middle of an operation
        n0 = rdy_q.size();
        do_start(C1, K1, t0);
        repeat (11) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("midreset_plain_text", bus.plain_text, '0);
        check("midreset_ready", 128'(bus.ready), '0);
        check("midreset_busy", 128'(bus.busy), '0);
        reset = 1'b0;
        repeat (25) @(negedge clk);
        check_int("midreset_no_ready", rdy_q.size() - n0, 0);
        do_start(C1, K1, t0);
        wait_ready(40, rc);
        check_int("post_reset_latency", rc - t0, 21);
        check("post_reset_pt", bus.plain_text, P1);

        // round trip through the forward cipher
        for (int v = 0; v < 1000; v++) begin
            pt = rand128();
            k  = rand128();
            do_start(m_encrypt(pt, k), k, t0);
            wait_ready(40, rc);
            check("xcheck_pt", bus.plain_text, pt);
        end

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
